// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle; 2*WIDTH result in hi/lo.
// Ports: clk, reset (async, active-low), start/op/a/b in;
// busy/done/div_zero/hi/lo out.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the multiplier runs out.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dzo_q, dzo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             in_div, in_dz;

  always_comb begin
    a_neg  = ~op[0] & a[WIDTH-1];
    b_neg  = ~op[0] & b[WIDTH-1];
    a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
    in_div = op[1];
    in_dz  = op[1] & (b == '0);
  end

  logic [W2-1:0]  mul_nxt;
  logic [W2:0]    shl;
  logic [WIDTH:0] top;
  logic [WIDTH:0] diff;
  logic [W2-1:0]  div_nxt;

  always_comb begin
    mul_nxt = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    shl     = {acc_q, 1'b0};
    top     = shl[W2:WIDTH];
    diff    = top - {1'b0, mplr_q};
    // A borrow means the trial subtraction failed: keep the shifted rest.
    if (diff[WIDTH])
      div_nxt = shl[W2-1:0];
    else
      div_nxt = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
  end

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1))
                         : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1))
                         : acc_q[W2-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dzo_d     = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = in_div;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dz_d      = in_dz;
          cnt_d     = '0;
          mplr_d    = b_mag;
          busy_d    = 1'b1;
          if (in_div) begin
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            mcand_d = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, a_mag};
          end
          if (in_dz) begin
            // Raw dividend is parked here so hi can return it untouched.
            mcand_d = {{WIDTH{1'b0}}, a};
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
            if (!in_div && (b_mag == '0))
              state_d = S_FIN;
`endif
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          acc_d = div_nxt;
        end else begin
          acc_d   = mul_nxt;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
        end
        if (cnt_q == CNT_LAST)
          state_d = S_FIN;
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div_q && ((mplr_q >> 1) == '0))
          state_d = S_FIN;
`endif
      end

      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dzo_d   = dz_q;
        if (dz_q) begin
          hi_d = mcand_q[WIDTH-1:0];
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dzo_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dzo_q     <= dzo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dzo_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): vector table, corner sequences,
// random ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int passed = 0;
  int total  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
  function automatic void model(input logic [1:0] o,
                                input logic [31:0] x, y,
                                output logic [31:0] eh, el,
                                output logic edz, output int elat);
    longint sx, sy, p, q, r;
    logic [63:0] up;
    logic [31:0] mag;
    sx = $signed(x);
    sy = $signed(y);
    edz = 1'b0;
    elat = 33;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (y == 0) begin
          eh = x; el = '1; edz = 1'b1; elat = 1;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mag = (o == 2'b00 && y[31]) ? (~y + 32'd1) : y;
      elat = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) elat = i + 2;
    end
`else
    mag = '0;
    if (mag != 0) elat = 0;
`endif
  endfunction

  // Issues one op in IDLE, scrambles inputs while busy, waits for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, y,
                        output logic [31:0] rh, rl, output logic rdz,
                        output int lat, output bit busy_ok,
                        output bit pulse_ok);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    busy_ok = busy;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    if (busy) busy_ok = 1'b0;
    rh = hi; rl = lo; rdz = div_zero;
    @(posedge clk); #1;
    pulse_ok = !done && !div_zero && hi === rh && lo === rl;
  endtask

  task automatic apply(input string nm, input logic [1:0] o,
                       input logic [31:0] x, y, eh, el, input logic edz);
    logic [31:0] rh, rl, mh, ml;
    logic rdz, mdz;
    int lat, elat;
    bit bok, pok;
    model(o, x, y, mh, ml, mdz, elat);
    run_op(o, x, y, rh, rl, rdz, lat, bok, pok);
    check({nm, " hi"}, rh, eh);
    check({nm, " lo"}, rl, el);
    check({nm, " div_zero"}, rdz, edz);
    check({nm, " latency"}, lat, elat);
    check({nm, " busy/pulse"}, {bok, pok}, 2'b11);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] rh, rl, mh, ml;
    logic rdz, mdz;
    int lat, elat, dcount;
    bit bok, pok;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[4]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[7]  = '{2'b11, 32'd50,       32'd7,        32'd1,        32'd7,        1'b0};
    vecs[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{2'b00, 32'd0,        32'd12345,    32'd0,        32'd0,        1'b0};
    vecs[10] = '{2'b01, 32'd5,        32'd1,        32'd0,        32'd5,        1'b0};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done/dz", {done, div_zero}, 2'b00);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 12; i++)
      apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // Start during a running divu must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd50; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == 4) begin
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
      end else if (lat == 5) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("busy-start latency", lat, 33);
    check("busy-start lo", lo, 32'd7);
    check("busy-start hi", hi, 32'd1);
    @(posedge clk); #1;
    check("busy-start not queued", busy, 1'b0);

    // Reset in the middle of an op clears everything at once.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h0000FFFF; b = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset hi/lo", {hi, lo}, 64'd0);
    check("midreset done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("midreset no done", dcount, 0);
    apply("post-reset multu", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    // Start held high: a second op is taken right after done.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held-start lo1", lo, 32'd12);
    a = 32'd5;
    @(posedge clk); #1;
    check("held-start reaccept", {busy, done}, 2'b10);
    start = 1'b0;
    model(2'b01, 32'd5, 32'd4, mh, ml, mdz, elat);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("held-start lo2", lo, 32'd20);
    check("held-start latency2", lat, elat);

    // Random ops against the reference model.
    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = $urandom_range(0, 15);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      model(ro, ra, rb, mh, ml, mdz, elat);
      run_op(ro, ra, rb, rh, rl, rdz, lat, bok, pok);
      check($sformatf("rnd%0d op%0d %h,%h", n, ro, ra, rb),
            {rh, rl}, {mh, ml});
      check($sformatf("rnd%0d dz", n), rdz, mdz);
      check($sformatf("rnd%0d latency", n), lat, elat);
      check($sformatf("rnd%0d busy/pulse", n), {bok, pok}, 2'b11);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit; successor to the fixed 32-bit mult/div pair feeding the CPU's HI/LO registers.
- Takes one operation per start pulse: signed or unsigned multiply or divide.
- Iterates one bit per cycle, then writes the 2*WIDTH result into hi/lo and pulses done.
- Adds what the fixed-width pair lacks: a busy/done handshake, signed/unsigned mode select, divide-by-zero flagging and width parametrisation.

Parameters:
- WIDTH, 32, operand width and width of each of hi and lo; legal range 8..64.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset: asserting low clears all state immediately; release is sampled on clk.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu; sampled together with start.
- a  input  WIDTH  multiplicand or dividend; sampled with start.
- b  input  WIDTH  multiplier or divisor; sampled with start.
- busy  output  1  high from the edge that accepts start until the edge that raises done.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle onward.
- hi  output  WIDTH  multiply: upper product half; divide: remainder.
- lo  output  WIDTH  multiply: lower product half; divide: quotient.
- div_zero  output  1  pulses with done when a divide had b==0.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE.
  - busy=0, done=0, div_zero=0, hi=0, lo=0.
  - Iteration counter and internal registers cleared.
  - An operation in flight is discarded; no done is produced for it.
- FSM states: IDLE, RUN, FIN.
- IDLE: at edge t0, if start=1:
  - Latch op.
  - Latch magnitudes |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - Latch the result-sign flags.
  - Clear counter; busy=1.
  - Next state is RUN, except a divide with b==0, which goes directly to FIN with the dz flag set.
- RUN, multiply: unsigned shift-add of the magnitudes, one multiplier bit per edge, into a 2*WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per edge.
- RUN exit: after WIDTH iterations (edge t0+WIDTH), go to FIN.
- FIN (edge t0+WIDTH+1, or t0+1 for divide-by-zero):
  - Apply sign correction and load hi/lo.
  - done=1 for exactly one cycle; busy=0.
  - div_zero equals the dz flag.
  - Return to IDLE.
- Latency: done rises WIDTH+1 edges after the accepting edge; 33 for WIDTH=32.
- Sign rules:
  - Signed product is negated (2*WIDTH two's complement) when a and b differ in sign.
  - Signed quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: hi=a unchanged, lo=all ones, div_zero=1.
- Signed overflow, a=MIN and b=-1: lo=MIN, hi=0 (wrap); no flag.
- start while busy or in FIN: ignored, not queued.
- start held high continuously: a new operation is accepted at the first edge in IDLE after done.
- hi/lo hold their value until the next FIN; inputs a, b and op may change freely while busy.
- -MIN magnitude is handled as the unsigned value 2^(WIDTH-1); internal magnitudes are WIDTH bits unsigned.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - In RUN for multiplies, if the remaining unshifted multiplier bits are all zero after an iteration, go directly to FIN.
  - A multiply with multiplier magnitude 0 goes from IDLE directly to FIN.
  - Result is unchanged; latency is variable, min 1 edge to done, max WIDTH+1.
  - Divide latency is unchanged.
- Not defined: every multiply takes exactly WIDTH+1 edges.

Test Plan:
- WIDTH=32, multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the accepting edge; busy high for those 33 cycles.
- mult, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- divu, a=100, b=0 -> done and div_zero pulse 1 edge after acceptance; hi=100, lo=0xFFFFFFFF.
- Start second op (multu 2*3) at cycle 5 of a running divu 50/7 -> second op ignored; lo=7, hi=1.
- Then pull reset low at cycle 10 of a new op -> busy=0, hi=lo=0 immediately; no done.
- After release, multu 2*3 -> lo=6, hi=0.
- With MULDIV_EARLY_OUT_EN: multu a=5, b=1 -> done 2 edges after acceptance, lo=5.
